bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL provide parameter: HOLD_LIMIT, 64, max cycles the owner may keep the bus while another master requests (0 = never preempt).
REQ-002 SHALL use one clock and an asynchronous, active-low reset, named clk and reset_.
REQ-003 SHALL provide port: clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL provide port: reset_  input  1  asynchronous active-low reset.
REQ-005 SHALL provide ports: M0Req_..M3Req_  input  1 each  bus request, active-low.
REQ-006 SHALL provide ports: M0Grnt_..M3Grnt_  output  1 each  bus grant, active-low.
REQ-007 SHALL provide ports: M0Addr..M3Addr  input  30 each  master word address.
REQ-008 SHALL provide ports: M0As_..M3As_  input  1 each  master address strobe, active-low.
REQ-009 SHALL provide ports: M0RW..M3RW  input  1 each  master read/write select.
REQ-010 SHALL provide ports: M0WrData..M3WrData  input  32 each  master write data.
REQ-011 SHALL provide port: BusAddr  output  30  shared-bus address.
REQ-012 SHALL provide ports: BusAs_, BusRW  output  1 each  shared-bus strobe and direction.
REQ-013 SHALL provide port: BusWrData  output  32  shared-bus write data.
REQ-014 SHALL provide port: Owner  output  2  index of current owner.
REQ-015 SHALL provide port: Preempt  output  1  one-cycle pulse when ownership is forced away.

Function
REQ-016 SHALL hold a 2-bit owner register; exactly one MxGrnt_ is low at all times, decoded combinationally from it.
REQ-017 SHALL keep ownership while the owner's Req_ is low, subject only to REQ-021.
REQ-018 SHALL, when the owner's Req_ is high, load at the next edge the first master with Req_ low in order owner+1, +2, +3 (mod 4).
REQ-019 SHALL leave the owner unchanged (bus parked) when no master requests.
REQ-020 SHALL hold a hold counter that clears on any owner change; it increments when the owner requests and some other master requests, clears otherwise, and saturates at HOLD_LIMIT.
REQ-021 SHALL, when HOLD_LIMIT is nonzero, the counter equals HOLD_LIMIT, and the owner's As_ is high, rotate ownership per REQ-018 order at the next edge even though the owner's Req_ is low; Preempt is high for exactly that cycle (registered, asserted in the cycle after the change).
REQ-022 SHALL never preempt while the owner's As_ is low; preemption defers until As_ goes high.
REQ-023 SHALL drive BusAddr, BusAs_, BusRW and BusWrData combinationally from the owner's inputs; non-owner As_ has no effect on the bus.
REQ-024 SHALL give each arbitration decision zero cycles of latency from the request sample: a decision made at edge N is reflected in Grnt_ and the bus mux after edge N.
REQ-025 SHALL treat simultaneous owner release and new requests per REQ-018; the releasing master is lowest priority.

Reset
REQ-026 SHALL, while reset_ is low, asynchronously set Owner=0, M0Grnt_=0, M1..M3Grnt_=1, hold counter=0 and Preempt=0.
REQ-027 SHALL, when reset asserts mid-transfer, abandon the transfer, with the bus mux following M0 immediately.

Verification
REQ-028 SHALL verify: reset release with all Req_ high -> Owner=0, M0Grnt_=0, others 1, bus mirrors M0.
REQ-029 SHALL verify: owner 0 requesting; M2 and M3 request; M0 releases -> next edge Owner=2; M2 releases -> Owner=3.
REQ-030 SHALL verify: owner 3 releases while M0 and M1 request -> Owner=0 (wrap-around).
REQ-031 SHALL verify: HOLD_LIMIT=4, M1 owns with As_ high and M2 requests -> after 4 counted cycles Owner=2 and Preempt pulses once.
REQ-032 SHALL verify: same as REQ-031 but M1 As_ low through cycle 10 -> no change until As_ rises, then Owner=2 next edge.
REQ-033 SHALL verify: reset_ low mid-transfer with Owner=2 -> Owner=0 and BusAddr=M0Addr without a clock edge.

Source files
------------

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - four-master round-robin bus arbiter with hold-limit preemption
module bus_arbiter #(
  parameter int HOLD_LIMIT = 64
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        M0Req_,
  input  logic        M1Req_,
  input  logic        M2Req_,
  input  logic        M3Req_,
  output logic        M0Grnt_,
  output logic        M1Grnt_,
  output logic        M2Grnt_,
  output logic        M3Grnt_,
  input  logic [29:0] M0Addr,
  input  logic [29:0] M1Addr,
  input  logic [29:0] M2Addr,
  input  logic [29:0] M3Addr,
  input  logic        M0As_,
  input  logic        M1As_,
  input  logic        M2As_,
  input  logic        M3As_,
  input  logic        M0RW,
  input  logic        M1RW,
  input  logic        M2RW,
  input  logic        M3RW,
  input  logic [31:0] M0WrData,
  input  logic [31:0] M1WrData,
  input  logic [31:0] M2WrData,
  input  logic [31:0] M3WrData,
  output logic [29:0] BusAddr,
  output logic        BusAs_,
  output logic        BusRW,
  output logic [31:0] BusWrData,
  output logic [1:0]  Owner,
  output logic        Preempt
);

  localparam int CW = (HOLD_LIMIT < 1) ? 1 : $clog2(HOLD_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(HOLD_LIMIT);

  logic [3:0]    req;
  logic [3:0]    as_n;
  logic [1:0]    owner_q, owner_d;
  logic [CW-1:0] hold_q, hold_d;
  logic          preempt_q, preempt_d;

  logic [1:0]    cand;
  logic [1:0]    idx;
  logic          own_req;
  logic          any_other;
  logic          force_rot;

  assign req  = ~{M3Req_, M2Req_, M1Req_, M0Req_};
  assign as_n = {M3As_, M2As_, M1As_, M0As_};

  always_comb begin
    cand      = owner_q;
    idx       = owner_q;
    any_other = 1'b0;
    own_req   = req[owner_q];
    // Scan farthest-first so the nearest requester after the owner wins.
    for (int k = 3; k >= 1; k--) begin
      idx = owner_q + 2'(k);
      if (req[idx]) begin
        cand      = idx;
        any_other = 1'b1;
      end
    end
    force_rot = (HOLD_LIMIT != 0) && (hold_q == LIMIT) && as_n[owner_q] && own_req;

    owner_d   = owner_q;
    hold_d    = '0;
    preempt_d = 1'b0;
    if ((!own_req || force_rot) && any_other) begin
      owner_d   = cand;
      preempt_d = force_rot;
    end else if (own_req && any_other) begin
      hold_d = (hold_q == LIMIT) ? hold_q : hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      owner_q   <= 2'd0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign M0Grnt_ = (owner_q != 2'd0);
  assign M1Grnt_ = (owner_q != 2'd1);
  assign M2Grnt_ = (owner_q != 2'd2);
  assign M3Grnt_ = (owner_q != 2'd3);
  assign Owner   = owner_q;
  assign Preempt = preempt_q;

  always_comb begin
    BusAddr   = M0Addr;
    BusAs_    = M0As_;
    BusRW     = M0RW;
    BusWrData = M0WrData;
    case (owner_q)
      2'd1: begin BusAddr = M1Addr; BusAs_ = M1As_; BusRW = M1RW; BusWrData = M1WrData; end
      2'd2: begin BusAddr = M2Addr; BusAs_ = M2As_; BusRW = M2RW; BusWrData = M2WrData; end
      2'd3: begin BusAddr = M3Addr; BusAs_ = M3As_; BusRW = M3RW; BusWrData = M3WrData; end
      default: ;
    endcase
  end

endmodule
